// File: rtl/spu_issue_pkg.sv
// ============================================================================
// Module   : spu_issue_pkg
// Purpose  : Shared types and constants for the dual-issue control block:
//            idle-slot encodings, pipe selector, decoded instruction bundle,
//            registered output slot and scoreboard counter width.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package spu_issue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h4020_0000;
    localparam logic [6:0]  NOP_ID    = 7'd0;
    localparam int          SB_W      = 4;

    typedef enum logic {
        PIPE_EVEN = 1'b0,
        PIPE_ODD  = 1'b1
    } pipe_t;

    // Decoded instruction as held in the pair buffer.
    typedef struct packed {
        logic [31:0] full_instr;
        logic [6:0]  instr_id;
        logic [2:0]  unit_id;
        pipe_t       pipe;
        logic [3:0]  latency;
        logic        reg_wr;
        logic [6:0]  reg_dst;
        logic [6:0]  ra_addr;
        logic        ra_use;
        logic [6:0]  rb_addr;
        logic        rb_use;
        logic [6:0]  rc_addr;
        logic        rc_use;
    } issue_bundle_t;

    // Fields actually presented on an output slot.
    typedef struct packed {
        logic        valid;
        logic [31:0] full_instr;
        logic [6:0]  instr_id;
        logic [6:0]  reg_dst;
        logic [2:0]  unit_id;
        logic [3:0]  latency;
        logic        reg_wr;
        logic [6:0]  ra_addr;
        logic [6:0]  rb_addr;
        logic [6:0]  rc_addr;
    } slot_t;

    function automatic slot_t nop_slot();
        slot_t s;
        s            = '0;
        s.full_instr = NOP_INSTR;
        s.instr_id   = NOP_ID;
        return s;
    endfunction

    function automatic slot_t to_slot(input issue_bundle_t b);
        slot_t s;
        s.valid      = 1'b1;
        s.full_instr = b.full_instr;
        s.instr_id   = b.instr_id;
        s.reg_dst    = b.reg_dst;
        s.unit_id    = b.unit_id;
        s.latency    = b.latency;
        s.reg_wr     = b.reg_wr;
        s.ra_addr    = b.ra_addr;
        s.rb_addr    = b.rb_addr;
        s.rc_addr    = b.rc_addr;
        return s;
    endfunction

    // Count loaded on issue: latency-1, floored at zero.
    function automatic logic [SB_W-1:0] sb_load(input logic [3:0] lat);
        return (lat == 4'd0) ? '0 : SB_W'(lat - 4'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dual_issue_ctrl_scoreboard.sv
// ============================================================================
// Module   : issue_scoreboard
// Purpose  : Per-register result-latency scoreboard. Two load ports (one per
//            issued instruction), six source lookups and two destination
//            lookups; reports a blocked flag per buffer entry.
// Ports    : clk, rst        clock, async active-high reset
//            ld_en_i[1:0]    load strobe  (bit0 = entry A, bit1 = entry B)
//            ld_dst_i[13:0]  load register address, 7 bits per port
//            ld_lat_i[7:0]   load latency, 4 bits per port
//            src_addr_i/src_use_i  sources 0-2 entry A, 3-5 entry B
//            dst_addr_i/dst_wr_i   destination lookup per entry
//            blocked_o[1:0]  RAW or WAW hazard per entry
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module issue_scoreboard
    import spu_issue_pkg::*;
#(
    parameter int NUM_REGS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ld_en_i,
    input  logic [13:0] ld_dst_i,
    input  logic [7:0]  ld_lat_i,
    input  logic [41:0] src_addr_i,
    input  logic [5:0]  src_use_i,
    input  logic [13:0] dst_addr_i,
    input  logic [1:0]  dst_wr_i,
    output logic [1:0]  blocked_o
);

    logic [SB_W-1:0] w_busy   [NUM_REGS];
    logic [SB_W-1:0] w_ld_val [2];
    logic [5:0]      w_src_hit;
    logic [1:0]      w_dst_hit;

    always_comb begin
        w_ld_val[0] = sb_load(ld_lat_i[3:0]);
        w_ld_val[1] = sb_load(ld_lat_i[7:4]);
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_busy
        logic [SB_W-1:0] busy_q;
        logic [SB_W-1:0] busy_d;

        // A load overrides the decrement on the same register.
        always_comb begin
            busy_d = busy_q;
            if (busy_q != '0) begin
                busy_d = busy_q - 1'b1;
            end
            if (ld_en_i[1] && (ld_dst_i[13:7] == 7'(r))) begin
                busy_d = w_ld_val[1];
            end
            if (ld_en_i[0] && (ld_dst_i[6:0] == 7'(r))) begin
                busy_d = w_ld_val[0];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                busy_q <= '0;
            end else begin
                busy_q <= busy_d;
            end
        end

        assign w_busy[r] = busy_q;
    end

    always_comb begin
        w_src_hit = '0;
        w_dst_hit = '0;
        for (int i = 0; i < 6; i++) begin
            w_src_hit[i] = src_use_i[i] && (w_busy[src_addr_i[i*7 +: 7]] != '0);
        end
        for (int j = 0; j < 2; j++) begin
            w_dst_hit[j] = dst_wr_i[j] && (w_busy[dst_addr_i[j*7 +: 7]] != '0);
        end
    end

    assign blocked_o[0] = (|w_src_hit[2:0]) | w_dst_hit[0];
    assign blocked_o[1] = (|w_src_hit[5:3]) | w_dst_hit[1];

endmodule

`default_nettype wire

// File: rtl/dual_issue_ctrl.sv
// ============================================================================
// Module   : dual_issue_ctrl
// Purpose  : In-order dual-issue stage. Buffers one instruction pair, checks
//            order, structural and RAW/WAW hazards against the scoreboard,
//            and drives registered even/odd slot bundles (NOP when idle).
// Ports    : clk, rst                async active-high reset
//            in_valid/in_ready       pair handshake, flush = branch redirect
//            in_{a,b}_*              decoded pair, a first in program order
//            out_{even,odd}_*        registered issued bundles
//            perf_{dual,single,stall} cycle counters (DUAL_ISSUE_PERF_EN only)
// Config   : `define DUAL_ISSUE_PERF_EN adds the performance counter outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dual_issue_ctrl
    import spu_issue_pkg::*;
#(
    parameter int NUM_REGS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    input  logic [31:0] in_a_full_instr,
    input  logic [6:0]  in_a_instr_id,
    input  logic [2:0]  in_a_unit_id,
    input  logic        in_a_pipe,
    input  logic [3:0]  in_a_latency,
    input  logic        in_a_reg_wr,
    input  logic [6:0]  in_a_reg_dst,
    input  logic [6:0]  in_a_ra_addr,
    input  logic        in_a_ra_use,
    input  logic [6:0]  in_a_rb_addr,
    input  logic        in_a_rb_use,
    input  logic [6:0]  in_a_rc_addr,
    input  logic        in_a_rc_use,
    input  logic [31:0] in_b_full_instr,
    input  logic [6:0]  in_b_instr_id,
    input  logic [2:0]  in_b_unit_id,
    input  logic        in_b_pipe,
    input  logic [3:0]  in_b_latency,
    input  logic        in_b_reg_wr,
    input  logic [6:0]  in_b_reg_dst,
    input  logic [6:0]  in_b_ra_addr,
    input  logic        in_b_ra_use,
    input  logic [6:0]  in_b_rb_addr,
    input  logic        in_b_rb_use,
    input  logic [6:0]  in_b_rc_addr,
    input  logic        in_b_rc_use,
    output logic        out_even_valid,
    output logic [31:0] out_even_full_instr,
    output logic [6:0]  out_even_instr_id,
    output logic [6:0]  out_even_reg_dst,
    output logic [2:0]  out_even_unit_id,
    output logic [3:0]  out_even_latency,
    output logic        out_even_reg_wr,
    output logic [6:0]  out_even_ra_addr,
    output logic [6:0]  out_even_rb_addr,
    output logic [6:0]  out_even_rc_addr,
    output logic        out_odd_valid,
    output logic [31:0] out_odd_full_instr,
    output logic [6:0]  out_odd_instr_id,
    output logic [6:0]  out_odd_reg_dst,
    output logic [2:0]  out_odd_unit_id,
    output logic [3:0]  out_odd_latency,
    output logic        out_odd_reg_wr,
    output logic [6:0]  out_odd_ra_addr,
    output logic [6:0]  out_odd_rb_addr,
    output logic [6:0]  out_odd_rc_addr
`ifdef DUAL_ISSUE_PERF_EN
    ,
    output logic [31:0] perf_dual,
    output logic [31:0] perf_single,
    output logic [31:0] perf_stall
`endif
);

    issue_bundle_t w_in_a, w_in_b;
    issue_bundle_t ent_a_q, ent_a_d, ent_b_q, ent_b_d;
    logic          vld_a_q, vld_a_d, vld_b_q, vld_b_d;
    slot_t         out_even_q, out_even_d, out_odd_q, out_odd_d;
    logic [1:0]    w_blk;
    logic          w_iss_a, w_iss_b, w_pair_ok, w_b_reads_a, w_accept;

    assign w_in_a = '{in_a_full_instr, in_a_instr_id, in_a_unit_id, pipe_t'(in_a_pipe),
                      in_a_latency, in_a_reg_wr, in_a_reg_dst, in_a_ra_addr, in_a_ra_use,
                      in_a_rb_addr, in_a_rb_use, in_a_rc_addr, in_a_rc_use};
    assign w_in_b = '{in_b_full_instr, in_b_instr_id, in_b_unit_id, pipe_t'(in_b_pipe),
                      in_b_latency, in_b_reg_wr, in_b_reg_dst, in_b_ra_addr, in_b_ra_use,
                      in_b_rb_addr, in_b_rb_use, in_b_rc_addr, in_b_rc_use};

    issue_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .ld_en_i    ({w_iss_b && ent_b_q.reg_wr, w_iss_a && ent_a_q.reg_wr}),
        .ld_dst_i   ({ent_b_q.reg_dst, ent_a_q.reg_dst}),
        .ld_lat_i   ({ent_b_q.latency, ent_a_q.latency}),
        .src_addr_i ({ent_b_q.rc_addr, ent_b_q.rb_addr, ent_b_q.ra_addr,
                      ent_a_q.rc_addr, ent_a_q.rb_addr, ent_a_q.ra_addr}),
        .src_use_i  ({ent_b_q.rc_use, ent_b_q.rb_use, ent_b_q.ra_use,
                      ent_a_q.rc_use, ent_a_q.rb_use, ent_a_q.ra_use}),
        .dst_addr_i ({ent_b_q.reg_dst, ent_a_q.reg_dst}),
        .dst_wr_i   ({ent_b_q.reg_wr, ent_a_q.reg_wr}),
        .blocked_o  (w_blk)
    );

    // Intra-pair RAW is invisible to the scoreboard until A has issued.
    assign w_b_reads_a = (ent_b_q.ra_use && (ent_b_q.ra_addr == ent_a_q.reg_dst)) ||
                         (ent_b_q.rb_use && (ent_b_q.rb_addr == ent_a_q.reg_dst)) ||
                         (ent_b_q.rc_use && (ent_b_q.rc_addr == ent_a_q.reg_dst));
    assign w_pair_ok = (ent_a_q.pipe != ent_b_q.pipe) &&
                       !(ent_a_q.reg_wr && w_b_reads_a) &&
                       !(ent_a_q.reg_wr && ent_b_q.reg_wr && (ent_a_q.reg_dst == ent_b_q.reg_dst));

    assign w_iss_a = vld_a_q && !w_blk[0] && !flush;
    // B is in order: it needs A gone already, or A leaving now alongside it.
    assign w_iss_b = vld_b_q && !w_blk[1] && !flush && (!vld_a_q || (w_iss_a && w_pair_ok));

    assign in_ready = !flush && (!vld_a_q || w_iss_a) && (!vld_b_q || w_iss_b);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        ent_a_d = ent_a_q;
        ent_b_d = ent_b_q;
        vld_a_d = vld_a_q && !w_iss_a;
        vld_b_d = vld_b_q && !w_iss_b;
        if (flush) begin
            vld_a_d = 1'b0;
            vld_b_d = 1'b0;
        end
        if (w_accept) begin
            ent_a_d = w_in_a;
            ent_b_d = w_in_b;
            vld_a_d = 1'b1;
            vld_b_d = |w_in_b;  // all-zero B marks a single-instruction pair
        end
    end

    // Routing is by pipe bit only; both issuing implies different pipes.
    always_comb begin
        out_even_d = nop_slot();
        out_odd_d  = nop_slot();
        if (w_iss_a) begin
            if (ent_a_q.pipe == PIPE_ODD) out_odd_d  = to_slot(ent_a_q);
            else                          out_even_d = to_slot(ent_a_q);
        end
        if (w_iss_b) begin
            if (ent_b_q.pipe == PIPE_ODD) out_odd_d  = to_slot(ent_b_q);
            else                          out_even_d = to_slot(ent_b_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_a_q    <= '0;
            ent_b_q    <= '0;
            vld_a_q    <= 1'b0;
            vld_b_q    <= 1'b0;
            out_even_q <= nop_slot();
            out_odd_q  <= nop_slot();
        end else begin
            ent_a_q    <= ent_a_d;
            ent_b_q    <= ent_b_d;
            vld_a_q    <= vld_a_d;
            vld_b_q    <= vld_b_d;
            out_even_q <= out_even_d;
            out_odd_q  <= out_odd_d;
        end
    end

    assign out_even_valid      = out_even_q.valid;
    assign out_even_full_instr = out_even_q.full_instr;
    assign out_even_instr_id   = out_even_q.instr_id;
    assign out_even_reg_dst    = out_even_q.reg_dst;
    assign out_even_unit_id    = out_even_q.unit_id;
    assign out_even_latency    = out_even_q.latency;
    assign out_even_reg_wr     = out_even_q.reg_wr;
    assign out_even_ra_addr    = out_even_q.ra_addr;
    assign out_even_rb_addr    = out_even_q.rb_addr;
    assign out_even_rc_addr    = out_even_q.rc_addr;
    assign out_odd_valid       = out_odd_q.valid;
    assign out_odd_full_instr  = out_odd_q.full_instr;
    assign out_odd_instr_id    = out_odd_q.instr_id;
    assign out_odd_reg_dst     = out_odd_q.reg_dst;
    assign out_odd_unit_id     = out_odd_q.unit_id;
    assign out_odd_latency     = out_odd_q.latency;
    assign out_odd_reg_wr      = out_odd_q.reg_wr;
    assign out_odd_ra_addr     = out_odd_q.ra_addr;
    assign out_odd_rb_addr     = out_odd_q.rb_addr;
    assign out_odd_rc_addr     = out_odd_q.rc_addr;

`ifdef DUAL_ISSUE_PERF_EN
    logic [31:0] perf_dual_q, perf_single_q, perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_dual_q   <= '0;
            perf_single_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (w_iss_a && w_iss_b) begin
                perf_dual_q <= perf_dual_q + 32'd1;
            end else if (w_iss_a ^ w_iss_b) begin
                perf_single_q <= perf_single_q + 32'd1;
            end else if (vld_a_q || vld_b_q) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_dual   = perf_dual_q;
    assign perf_single = perf_single_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dual_issue_ctrl.sv
// ============================================================================
// Module   : tb_dual_issue_ctrl
// Purpose  : Self-checking bench for dual_issue_ctrl. Directed scenarios then
//            random pairs, checked against a reference model that tracks the
//            absolute cycle at which each register becomes readable.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dual_issue_ctrl;

    typedef struct packed {
        logic [31:0] fi;
        logic [6:0]  id;
        logic [2:0]  unit;
        logic        pipe;
        logic [3:0]  lat;
        logic        wr;
        logic [6:0]  dst;
        logic [6:0]  ra, rb, rc;
        logic        ua, ub, uc;
    } ins_t;

    typedef struct packed {
        logic        v;
        logic [31:0] fi;
        logic [6:0]  id;
        logic [6:0]  dst;
        logic [2:0]  unit;
        logic [3:0]  lat;
        logic        wr;
        logic [6:0]  ra, rb, rc;
    } slot_t;

    logic clk = 1'b0;
    logic rst, in_valid, flush, in_ready;
    ins_t ia, ib;

    logic        ev_v, od_v, ev_wr, od_wr;
    logic [31:0] ev_fi, od_fi;
    logic [6:0]  ev_id, od_id, ev_dst, od_dst, ev_ra, od_ra, ev_rb, od_rb, ev_rc, od_rc;
    logic [2:0]  ev_unit, od_unit;
    logic [3:0]  ev_lat, od_lat;
`ifdef DUAL_ISSUE_PERF_EN
    logic [31:0] perf_dual, perf_single, perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    ins_t m_a, m_b;
    bit   m_va, m_vb;
    int   ready_at [128];
    int   cyc;

    always #5 clk = ~clk;

    dual_issue_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .in_a_full_instr(ia.fi), .in_a_instr_id(ia.id), .in_a_unit_id(ia.unit),
        .in_a_pipe(ia.pipe), .in_a_latency(ia.lat), .in_a_reg_wr(ia.wr), .in_a_reg_dst(ia.dst),
        .in_a_ra_addr(ia.ra), .in_a_ra_use(ia.ua), .in_a_rb_addr(ia.rb), .in_a_rb_use(ia.ub),
        .in_a_rc_addr(ia.rc), .in_a_rc_use(ia.uc),
        .in_b_full_instr(ib.fi), .in_b_instr_id(ib.id), .in_b_unit_id(ib.unit),
        .in_b_pipe(ib.pipe), .in_b_latency(ib.lat), .in_b_reg_wr(ib.wr), .in_b_reg_dst(ib.dst),
        .in_b_ra_addr(ib.ra), .in_b_ra_use(ib.ua), .in_b_rb_addr(ib.rb), .in_b_rb_use(ib.ub),
        .in_b_rc_addr(ib.rc), .in_b_rc_use(ib.uc),
        .out_even_valid(ev_v), .out_even_full_instr(ev_fi), .out_even_instr_id(ev_id),
        .out_even_reg_dst(ev_dst), .out_even_unit_id(ev_unit), .out_even_latency(ev_lat),
        .out_even_reg_wr(ev_wr), .out_even_ra_addr(ev_ra), .out_even_rb_addr(ev_rb),
        .out_even_rc_addr(ev_rc),
        .out_odd_valid(od_v), .out_odd_full_instr(od_fi), .out_odd_instr_id(od_id),
        .out_odd_reg_dst(od_dst), .out_odd_unit_id(od_unit), .out_odd_latency(od_lat),
        .out_odd_reg_wr(od_wr), .out_odd_ra_addr(od_ra), .out_odd_rb_addr(od_rb),
        .out_odd_rc_addr(od_rc)
`ifdef DUAL_ISSUE_PERF_EN
        , .perf_dual(perf_dual), .perf_single(perf_single), .perf_stall(perf_stall)
`endif
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic slot_t idle_slot();
        slot_t s = '0;
        s.fi = 32'h4020_0000;
        return s;
    endfunction

    function automatic slot_t issued(input ins_t x);
        slot_t s;
        s = '{1'b1, x.fi, x.id, x.dst, x.unit, x.lat, x.wr, x.ra, x.rb, x.rc};
        return s;
    endfunction

    function automatic slot_t obs_even();
        return '{ev_v, ev_fi, ev_id, ev_dst, ev_unit, ev_lat, ev_wr, ev_ra, ev_rb, ev_rc};
    endfunction

    function automatic slot_t obs_odd();
        return '{od_v, od_fi, od_id, od_dst, od_unit, od_lat, od_wr, od_ra, od_rb, od_rc};
    endfunction

    function automatic bit reads(input ins_t x, input logic [6:0] r);
        return (x.ua && x.ra == r) || (x.ub && x.rb == r) || (x.uc && x.rc == r);
    endfunction

    // A register is unreadable until its producer's latency has elapsed.
    function automatic bit not_ready(input logic [6:0] r);
        return cyc < ready_at[r];
    endfunction

    function automatic bit hazard(input ins_t x);
        return (x.ua && not_ready(x.ra)) || (x.ub && not_ready(x.rb)) ||
               (x.uc && not_ready(x.rc)) || (x.wr && not_ready(x.dst));
    endfunction

    function automatic ins_t mk(input logic [31:0] fi, input logic pipe, input logic [3:0] lat,
                                input logic wr, input logic [6:0] dst,
                                input logic [6:0] ra, input logic [6:0] rb);
        ins_t x = '0;
        x.fi = fi; x.id = fi[30:24]; x.unit = fi[2:0]; x.pipe = pipe; x.lat = lat;
        x.wr = wr; x.dst = dst; x.ra = ra; x.ua = (ra != 0); x.rb = rb; x.ub = (rb != 0);
        return x;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t x;
        logic [31:0] t;
        t = $urandom;
        x.fi = t | 32'h1;
        t = $urandom;
        x.id = t[6:0]; x.unit = t[9:7]; x.pipe = t[10]; x.wr = t[11];
        x.ua = t[12]; x.ub = t[13]; x.uc = t[14];
        x.lat = 4'($urandom_range(0, 7));
        x.dst = 7'($urandom_range(0, 7));
        x.ra  = 7'($urandom_range(0, 7));
        x.rb  = 7'($urandom_range(0, 7));
        x.rc  = 7'($urandom_range(0, 7));
        return x;
    endfunction

    // One clock: drive at negedge, check in_ready, then check slots after the edge.
    task automatic step(input bit v, input ins_t a, input ins_t b, input bit bp, input bit fl);
        bit    ia_go, ib_go, pair_ok, rdy;
        slot_t exp_s [2];
        in_valid = v; ia = a; ib = bp ? b : '0; flush = fl;
        #1;
        ia_go   = m_va && !hazard(m_a) && !fl;
        pair_ok = (m_a.pipe != m_b.pipe) && !(m_a.wr && reads(m_b, m_a.dst)) &&
                  !(m_a.wr && m_b.wr && m_a.dst == m_b.dst);
        ib_go   = m_vb && !hazard(m_b) && !fl && (!m_va || (ia_go && pair_ok));
        rdy     = !fl && (!m_va || ia_go) && (!m_vb || ib_go);
        check("in_ready", 96'(in_ready), 96'(rdy));
        exp_s[0] = idle_slot();
        exp_s[1] = idle_slot();
        if (ia_go) exp_s[m_a.pipe] = issued(m_a);
        if (ib_go) exp_s[m_b.pipe] = issued(m_b);
        @(posedge clk);
        #1;
        check("even_slot", 96'(obs_even()), 96'(exp_s[0]));
        check("odd_slot",  96'(obs_odd()),  96'(exp_s[1]));
        if (ia_go && m_a.wr) ready_at[m_a.dst] = cyc + int'(m_a.lat);
        if (ib_go && m_b.wr) ready_at[m_b.dst] = cyc + int'(m_b.lat);
        if (ia_go) m_va = 1'b0;
        if (ib_go) m_vb = 1'b0;
        if (fl) begin m_va = 1'b0; m_vb = 1'b0; end
        if (v && rdy) begin m_a = a; m_b = b; m_va = 1'b1; m_vb = bp; end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        m_va = 1'b0; m_vb = 1'b0; m_a = '0; m_b = '0;
        for (int r = 0; r < 128; r++) ready_at[r] = 0;
    endtask

    initial begin
        ins_t ta, tb;
        int   first;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; ia = '0; ib = '0;
        cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", 96'(in_ready), 96'(1));
        check("reset_even", 96'(obs_even()), 96'(idle_slot()));
        check("reset_odd",  96'(obs_odd()),  96'(idle_slot()));
        @(negedge clk);

        // 1: even fa + odd lqd, scoreboard clear -> dual issue
        ta = mk(32'h5800_0183, 1'b0, 4'd6, 1'b1, 7'd3, 7'd1, 7'd2);
        tb = mk(32'h3400_0284, 1'b1, 4'd6, 1'b1, 7'd4, 7'd10, 7'd0);
        step(1'b1, ta, tb, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check("t1_even_fi", 96'(ev_fi), 96'(ta.fi));
        check("t1_odd_fi",  96'(od_fi), 96'(tb.fi));
        idle(8);

        // 2: both even -> serialised over two cycles
        ta = mk(32'h1800_0021, 1'b0, 4'd2, 1'b1, 7'd20, 7'd11, 7'd0);
        tb = mk(32'h1800_0022, 1'b0, 4'd2, 1'b1, 7'd21, 7'd12, 7'd0);
        step(1'b1, ta, tb, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check("t2_even_a", 96'(ev_fi), 96'(ta.fi));
        check("t2_odd_nop", 96'(od_v), 96'(0));
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check("t2_even_b", 96'(ev_fi), 96'(tb.fi));
        idle(4);

        // 3: B reads A's r5 (lat 6) -> B issues six cycles after A
        ta = mk(32'h1800_0103, 1'b0, 4'd6, 1'b1, 7'd5, 7'd13, 7'd0);
        tb = mk(32'h3400_0104, 1'b1, 4'd1, 1'b1, 7'd6, 7'd5, 7'd0);
        step(1'b1, ta, tb, 1'b1, 1'b0);
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0);
            if (od_v && first < 0) first = k;
        end
        check("t3_b_issue_step", 96'(first), 96'(7));

        // 4: A odd, B even -> both issue, routed by pipe bit
        ta = mk(32'h3600_0205, 1'b1, 4'd4, 1'b1, 7'd14, 7'd15, 7'd0);
        tb = mk(32'h1800_0206, 1'b0, 4'd2, 1'b1, 7'd16, 7'd17, 7'd0);
        step(1'b1, ta, tb, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check("t4_odd_a",  96'(od_fi), 96'(ta.fi));
        check("t4_even_b", 96'(ev_fi), 96'(tb.fi));
        idle(6);

        // 5: flush while B stalls on r7; r7 keeps counting down afterwards
        ta = mk(32'h1800_0307, 1'b0, 4'd7, 1'b1, 7'd7, 7'd18, 7'd0);
        tb = mk(32'h3400_0308, 1'b1, 4'd2, 1'b1, 7'd23, 7'd7, 7'd0);
        step(1'b1, ta, tb, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, tb, '0, 1'b0, 1'b1);
        check("t5_even_nop", 96'(ev_v), 96'(0));
        check("t5_odd_nop",  96'(od_v), 96'(0));
        ta = mk(32'h1800_0309, 1'b0, 4'd2, 1'b1, 7'd24, 7'd7, 7'd0);
        step(1'b1, ta, '0, 1'b0, 1'b0);
        idle(8);

        // 6: async reset while B stalls; scoreboard cleared afterwards
        ta = mk(32'h1800_040a, 1'b0, 4'd7, 1'b1, 7'd9, 7'd19, 7'd0);
        tb = mk(32'h3400_040b, 1'b1, 4'd2, 1'b1, 7'd25, 7'd9, 7'd0);
        step(1'b1, ta, tb, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_async_even", 96'(obs_even()), 96'(idle_slot()));
        check("t6_async_odd",  96'(obs_odd()),  96'(idle_slot()));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        model_reset();
        ta = mk(32'h1800_040c, 1'b0, 4'd3, 1'b1, 7'd26, 7'd9, 7'd0);
        tb = mk(32'h3400_040d, 1'b1, 4'd3, 1'b1, 7'd27, 7'd9, 7'd0);
        step(1'b1, ta, tb, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check("t6_even_v", 96'(ev_v), 96'(1));
        check("t6_odd_v",  96'(od_v), 96'(1));
        idle(4);

        // Random pairs on a small register set to provoke hazards
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) < 7, rnd_ins(), rnd_ins(),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
